// File: rtl/ps2_pkg.sv
// Shared PS/2 command bytes, completion status codes and arbiter state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
    localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
    localparam logic [7:0] PS2_CMD_RATE   = 8'hF3;
    localparam logic [7:0] PS2_ACK        = 8'hFA;
    localparam logic [7:0] PS2_RESEND     = 8'hFE;
    localparam logic [7:0] PS2_BAT_PASS   = 8'hAA;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'b00,
        STATUS_NACK    = 2'b01,
        STATUS_RX_ERR  = 2'b10,
        STATUS_TIMEOUT = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_SENT = 3'd2,
        ST_WAIT_ACK  = 3'd3,
        ST_DONE      = 3'd4
    } arb_state_e;

    typedef struct packed {
        status_e    status;
        logic [7:0] reply;
    } result_t;

    // Final status for any reply that is not a resend request.
    function automatic status_e classify_reply(input logic [1:0] err, input logic [7:0] data);
        if (err != 2'b00) begin
            return STATUS_RX_ERR;
        end
        if (data == PS2_ACK) begin
            return STATUS_OK;
        end
        return STATUS_RX_ERR;
    endfunction

endpackage

// File: rtl/ps2_timeout_ctr.sv
// Saturating wait-state timer; expired_o is registered and tracks (count >= LIMIT).
module ps2_timeout_ctr #(
    parameter int unsigned LIMIT = 2000000,
    parameter int unsigned W     = 21
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;
    logic         expired_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (cnt_d >= W'(LIMIT));
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/ps2_cmd_arbiter.sv
// Round-robin arbiter sharing one PS/2 transmitter/receiver pair between two command
// requesters; owns the receiver for the span of a transaction, passes it through otherwise.
module ps2_cmd_arbiter
    import ps2_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 2000000,
    parameter int unsigned TIMER_W     = 21,
    parameter int unsigned MAX_RETRY   = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic [7:0] req_byte0_i,
    input  logic [7:0] req_byte1_i,
    output logic [1:0] gnt_o,
    output logic [1:0] done_o,
    output logic [1:0] status_o,
    output logic [7:0] reply_o,
    output logic       send_byte_o,
    output logic [7:0] byte_to_send_o,
    input  logic       byte_sent_i,
    input  logic       byte_ready_i,
    input  logic [7:0] byte_read_i,
    input  logic [1:0] byte_error_code_i,
    output logic       read_enable_c_o,
    output logic       rx_ready_c_o,
    output logic [7:0] rx_byte_c_o,
    output logic [1:0] rx_err_c_o,
    input  logic       rx_read_en_i
);

    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    arb_state_e         state_q, state_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         done_q, done_d;
    result_t            res_q, res_d;
    logic               send_q, send_d;
    logic [7:0]         byte_q, byte_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               last_q, last_d;
    logic               grant_sel_c;
    logic               timer_clr_c;
    logic               timer_en_c;
    logic               timer_expired;
    logic               own_read_c;
    logic               owned_c;

    ps2_timeout_ctr #(
        .LIMIT (ACK_TIMEOUT),
        .W     (TIMER_W)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (timer_clr_c),
        .en_i      (timer_en_c),
        .expired_o (timer_expired)
    );

    // A lone requester always wins; on a tie the one not served last goes next.
    assign grant_sel_c = (req_i == 2'b11) ? ~last_q : req_i[1];

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= 2'b00;
            done_q  <= 2'b00;
            res_q   <= '{status: STATUS_OK, reply: 8'h00};
            send_q  <= 1'b0;
            byte_q  <= PS2_CMD_RESET;
            retry_q <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            res_q   <= res_d;
            send_q  <= send_d;
            byte_q  <= byte_d;
            retry_q <= retry_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 2'b00;
        res_d       = res_q;
        send_d      = 1'b0;
        byte_d      = byte_q;
        retry_d     = retry_q;
        last_d      = last_q;
        timer_clr_c = 1'b0;
        timer_en_c  = 1'b0;
        own_read_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_i != 2'b00) begin
                    gnt_d   = grant_sel_c ? 2'b10 : 2'b01;
                    byte_d  = grant_sel_c ? req_byte1_i : req_byte0_i;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                send_d      = 1'b1;
                timer_clr_c = 1'b1;
                state_d     = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                timer_en_c = 1'b1;
                if (byte_sent_i) begin
                    timer_clr_c = 1'b1;
                    state_d     = ST_WAIT_ACK;
                end else if (timer_expired) begin
                    res_d   = '{status: STATUS_TIMEOUT, reply: 8'h00};
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT_ACK: begin
                timer_en_c = 1'b1;
                if (byte_ready_i) begin
                    own_read_c = 1'b1;
                    if ((byte_error_code_i == 2'b00) && (byte_read_i == PS2_RESEND)
                        && (retry_q < RETRY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = ST_SEND;
                    end else begin
                        // Spent resends surface as NACK; everything else is classified.
                        if ((byte_error_code_i == 2'b00) && (byte_read_i == PS2_RESEND)) begin
                            res_d.status = STATUS_NACK;
                        end else begin
                            res_d.status = classify_reply(byte_error_code_i, byte_read_i);
                        end
                        res_d.reply = byte_read_i;
                        done_d      = gnt_q;
                        state_d     = ST_DONE;
                    end
                end else if (timer_expired) begin
                    res_d   = '{status: STATUS_TIMEOUT, reply: 8'h00};
                    done_d  = gnt_q;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                gnt_d   = 2'b00;
                retry_d = '0;
                last_d  = gnt_q[1];
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign owned_c         = (state_q != ST_IDLE);
    assign read_enable_c_o = owned_c ? own_read_c : rx_read_en_i;
    assign rx_ready_c_o    = owned_c ? 1'b0 : byte_ready_i;
    assign rx_byte_c_o     = byte_read_i;
    assign rx_err_c_o      = byte_error_code_i;

    assign gnt_o          = gnt_q;
    assign done_o         = done_q;
    assign status_o       = 2'(res_q.status);
    assign reply_o        = res_q.reply;
    assign send_byte_o    = send_q;
    assign byte_to_send_o = byte_q;

endmodule
